// File: rtl/nios_pio_gen.sv
// Avalon-MM PIO: output register with set/clear, direction, synchronised inputs, edge capture, IRQ.
// Optional NIOS_PIO_GEN_BITCLR_EN: EDGE writes clear only the bits written as 1 (w1c).
module nios_pio_gen #(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0,
  parameter int          SYNC_STAGES = 2,
  parameter int          EDGE_TYPE   = 0,
  parameter int          IRQ_TYPE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] A_DATA = 3'd0, A_DIR = 3'd1, A_MASK = 3'd2, A_EDGE = 3'd3,
                         A_OSET = 3'd4, A_OCLR = 3'd5;

  logic [WIDTH-1:0] data_q, data_d, dir_q, dir_d, mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d, prev_q, prev_d;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [31:0] rdata_q, rdata_d, rd_word;
  logic [WIDTH-1:0] wd, in_sync, edge_det, clr_mask, irq_src;
  logic wr, rd;
  logic unused_wd;

  assign wr        = chipselect & ~write_n;
  assign rd        = chipselect & ~read_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign in_sync   = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = '0;
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    prev_d = in_sync;
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = in_sync & ~prev_q;
      1:       edge_det = ~in_sync & prev_q;
      default: edge_det = in_sync ^ prev_q;
    endcase
  end

  always_comb begin
    clr_mask = '0;
    if (wr && address == A_EDGE) begin
`ifdef NIOS_PIO_GEN_BITCLR_EN
      clr_mask = wd;
`else
      clr_mask = '1;
`endif
    end
    // A fresh edge wins over a clear in the same cycle so no event is lost.
    edge_d = (edge_q & ~clr_mask) | edge_det;
  end

  always_comb begin
    data_d = data_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    if (wr) begin
      case (address)
        A_DATA:  data_d = wd;
        A_DIR:   dir_d  = wd;
        A_MASK:  mask_d = wd;
        A_OSET:  data_d = data_q | wd;
        A_OCLR:  data_d = data_q & ~wd;
        default: ;
      endcase
    end
  end

  // Read mux uses pre-write register values, so a simultaneous write is not visible.
  always_comb begin
    rd_word = '0;
    case (address)
      A_DATA:  rd_word[WIDTH-1:0] = (dir_q & data_q) | (~dir_q & in_sync);
      A_DIR:   rd_word[WIDTH-1:0] = dir_q;
      A_MASK:  rd_word[WIDTH-1:0] = mask_q;
      A_EDGE:  rd_word[WIDTH-1:0] = edge_q;
      default: ;
    endcase
    rdata_d = rd ? rd_word : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= RESET_VALUE[WIDTH-1:0];
      dir_q   <= DIR_RESET[WIDTH-1:0];
      mask_q  <= '0;
      edge_q  <= '0;
      prev_q  <= '0;
      sync_q  <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      dir_q   <= dir_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      prev_q  <= prev_d;
      sync_q  <= sync_d;
      rdata_q <= rdata_d;
    end
  end

  assign irq_src  = (IRQ_TYPE == 1) ? in_sync : edge_q;
  assign irq      = |(irq_src & mask_q);
  assign readdata = rdata_q;
  assign out_port = data_q;
  assign oe       = dir_q;

endmodule

// File: tb/tb_nios_pio_gen.sv
// Directed bench for nios_pio_gen (WIDTH=8) with a register-map model checked every cycle.
module tb_nios_pio_gen;
  localparam int W = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset, chipselect, write_n, read_n, irq;
  logic [2:0]  address;
  logic [31:0] writedata, readdata;
  logic [W-1:0] in_port, out_port, oe;

  int checks = 0;
  int failures = 0;

  nios_pio_gen #(.WIDTH(W), .RESET_VALUE(32'hA5), .DIR_RESET(32'h0F), .SYNC_STAGES(S),
                 .EDGE_TYPE(0), .IRQ_TYPE(0)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Model: register map state plus a history of sampled pins; in_sync is the pin value
  // sampled S edges ago, prev the one S+1 edges ago.
  logic [W-1:0] m_out, m_dir, m_mask, m_edge;
  logic [31:0]  m_rd;
  logic [W-1:0] hist [0:S];
  bit m_ok = 0;

  always @(posedge clk) begin : model
    logic [W-1:0] s, p, ev, v;
    if (reset) begin
      m_out = 8'hA5; m_dir = 8'h0F; m_mask = '0; m_edge = '0; m_rd = '0;
      for (int k = 0; k <= S; k++) hist[k] = '0;
      m_ok = 1;
    end else if (m_ok) begin
      s  = hist[S-1];
      p  = hist[S];
      ev = s & ~p;
      v  = writedata[W-1:0];
      if (chipselect && !read_n) begin
        case (address)
          3'd0: m_rd = {24'h0, (m_dir & m_out) | (~m_dir & s)};
          3'd1: m_rd = {24'h0, m_dir};
          3'd2: m_rd = {24'h0, m_mask};
          3'd3: m_rd = {24'h0, m_edge};
          default: m_rd = 0;
        endcase
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_out = v;
          3'd1: m_dir = v;
          3'd2: m_mask = v;
`ifdef NIOS_PIO_GEN_BITCLR_EN
          3'd3: m_edge = m_edge & ~v;
`else
          3'd3: m_edge = '0;
`endif
          3'd4: m_out = m_out | v;
          3'd5: m_out = m_out & ~v;
          default: ;
        endcase
      end
      m_edge = m_edge | ev;
      for (int k = S; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = in_port;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cyc_out_port", {24'h0, out_port}, {24'h0, m_out});
      chk("cyc_oe", {24'h0, oe}, {24'h0, m_dir});
      chk("cyc_irq", {31'h0, irq}, {31'h0, |(m_edge & m_mask)});
      chk("cyc_readdata", readdata, m_rd);
    end
  end

  task automatic bus(input bit w, input bit r, input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = !w; read_n = !r; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; writedata = 32'h0;
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = 3'd0; writedata = 32'h0; in_port = '0;
    repeat (2) @(negedge clk);
    chk("t1_out_port", {24'h0, out_port}, 32'hA5);
    chk("t1_oe", {24'h0, oe}, 32'h0F);
    chk("t1_irq", {31'h0, irq}, 32'h0);
    chk("t1_readdata", readdata, 32'h0);
    reset = 1'b0;

    bus(1, 0, 3'd0, 32'hFFFF_FFF0);
    bus(1, 0, 3'd4, 32'h0F);
    bus(1, 0, 3'd5, 32'h30);
    chk("t2_out_port", {24'h0, out_port}, 32'hCF);
    bus(1, 0, 3'd1, 32'hFFFF_FFFF);
    bus(0, 1, 3'd0, 32'h0);
    chk("t2_rd_data", readdata, 32'hCF);
    bus(0, 1, 3'd4, 32'h0);
    chk("t2_rd_outset", readdata, 32'h0);
    bus(1, 1, 3'd0, 32'h12);
    chk("wr_rd_same_cycle", readdata, 32'hCF);
    chk("wr_rd_new_out", {24'h0, out_port}, 32'h12);

    bus(1, 0, 3'd2, 32'h1);
    in_port = 8'h01;
    repeat (2) @(negedge clk);
    chk("t3_irq_early", {31'h0, irq}, 32'h0);
    @(negedge clk);
    chk("t3_irq_set", {31'h0, irq}, 32'h1);
    bus(0, 1, 3'd3, 32'h0);
    chk("t3_rd_edge", readdata, 32'h1);
    bus(1, 0, 3'd3, 32'h1);
    chk("t3_irq_clr", {31'h0, irq}, 32'h0);

    in_port = 8'h03;
    repeat (2) @(negedge clk);
    bus(1, 0, 3'd3, 32'h2);
    bus(0, 1, 3'd3, 32'h0);
    chk("t4_clear_race", readdata, 32'h2);

    in_port = 8'h00;
    repeat (4) @(negedge clk);
    bus(1, 0, 3'd3, 32'hFF);
    bus(0, 1, 3'd3, 32'h0);
    chk("t5_cleared", readdata, 32'h0);
    in_port = 8'h03;
    repeat (4) @(negedge clk);
    bus(0, 1, 3'd3, 32'h0);
    chk("t5_capture", readdata, 32'h3);
    bus(1, 0, 3'd3, 32'h1);
    bus(0, 1, 3'd3, 32'h0);
`ifdef NIOS_PIO_GEN_BITCLR_EN
    chk("t5_w1c", readdata, 32'h2);
`else
    chk("t5_clr_all", readdata, 32'h0);
`endif

    bus(1, 0, 3'd1, 32'h0F);
    bus(1, 0, 3'd0, 32'hAA);
    in_port = 8'h55;
    repeat (4) @(negedge clk);
    bus(0, 1, 3'd0, 32'h0);
    chk("t6_mixed_dir", readdata, 32'h5A);
    bus(1, 0, 3'd2, 32'hFFFF_FFFF);
    bus(0, 1, 3'd2, 32'h0);
    chk("t6_mask_upper0", readdata, 32'hFF);
    bus(1, 0, 3'd7, 32'h00);
    chk("wr7_ignored", {24'h0, out_port}, 32'hAA);
    bus(0, 1, 3'd6, 32'h0);
    chk("rd6_zero", readdata, 32'h0);

    chipselect = 1'b1; read_n = 1'b0; address = 3'd1; reset = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read_n = 1'b1; reset = 1'b0;
    chk("rst_mid_rd", readdata, 32'h0);
    chk("rst_out_port", {24'h0, out_port}, 32'hA5);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
